// File: rtl/card_deck_if.sv
// Request/response bundle for the card deck queue.
// The master drives the requests; the slave (the deck) returns the dealt card and status.
interface card_deck_if #(
   parameter int CARD_W = 16
);
   logic              init;
   logic              store_en;
   logic [CARD_W-1:0] card_in;
   logic              deal_en;
   logic [CARD_W-1:0] card_out;
   logic              card_valid;
   logic [5:0]        count;
   logic              empty;
   logic              full;
   logic              busy;
   logic              err;

   modport master (
      output init, store_en, card_in, deal_en,
      input  card_out, card_valid, count, empty, full, busy, err
   );

   modport slave (
      input  init, store_en, card_in, deal_en,
      output card_out, card_valid, count, empty, full, busy, err
   );
endinterface

// File: rtl/card_deck.sv
// Card deck queue: a circular buffer of cards with deal (pop) and store (push)
// operations and a 52-cycle init fill that loads an ordered deck.
module card_deck #(
   parameter int DEPTH  = 52,
   parameter int CARD_W = 16
) (
   input  logic       clock,
   input  logic       reset,
   card_deck_if.slave bus
);

   localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);
   localparam logic [5:0] FULL_CNT = 6'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Pointer increment with wrap from the last slot back to slot 0.
   function automatic logic [5:0] ptr_next(input logic [5:0] p);
      logic [5:0] n;
      if (p == LAST_IDX) begin
         n = 6'd0;
      end else begin
         n = p + 6'd1;
      end
      return n;
   endfunction

   // Card encoding: rank in [3:0], suit in [5:4], upper bits zero.
   function automatic logic [CARD_W-1:0] make_card(input logic [1:0] suit, input logic [3:0] rank);
      logic [CARD_W-1:0] c;
      c      = '0;
      c[3:0] = rank;
      c[5:4] = suit;
      return c;
   endfunction

   state_t            state_q, state_d;
   logic [5:0]        head_q, head_d;
   logic [5:0]        tail_q, tail_d;
   logic [5:0]        count_q, count_d;
   logic [CARD_W-1:0] card_out_q, card_out_d;
   logic              card_valid_q, card_valid_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic [3:0]        rank_q, rank_d;
   logic [1:0]        suit_q, suit_d;

   logic [CARD_W-1:0] mem_q [DEPTH];

   logic              deal_ok_s;
   logic              store_ok_s;
   logic              wr_en_s;
   logic [5:0]        wr_addr_s;
   logic [CARD_W-1:0] wr_data_s;

   // Next-state logic for the FSM, pointers, count, outputs and buffer write port.
   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      card_out_d   = card_out_q;
      card_valid_d = 1'b0;
      err_d        = err_q;
      rank_d       = rank_q;
      suit_d       = suit_q;
      deal_ok_s    = 1'b0;
      store_ok_s   = 1'b0;
      wr_en_s      = 1'b0;
      wr_addr_s    = tail_q;
      wr_data_s    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.init) begin
               // Init wins over any queue request in the same cycle.
               state_d = ST_FILL;
               head_d  = 6'd0;
               tail_d  = 6'd0;
               count_d = 6'd0;
               err_d   = 1'b0;
               rank_d  = 4'd1;
               suit_d  = 2'd0;
            end else begin
               deal_ok_s  = bus.deal_en && (count_q != 6'd0);
               // A full queue still takes a store when the same cycle frees a slot.
               store_ok_s = bus.store_en && ((count_q != FULL_CNT) || deal_ok_s);

               if (deal_ok_s) begin
                  card_out_d   = mem_q[head_q];
                  card_valid_d = 1'b1;
                  head_d       = ptr_next(head_q);
               end else begin
                  card_valid_d = 1'b0;
               end

               if (store_ok_s) begin
                  wr_en_s   = 1'b1;
                  wr_addr_s = tail_q;
                  wr_data_s = bus.card_in;
                  tail_d    = ptr_next(tail_q);
               end else begin
                  wr_en_s = 1'b0;
               end

               case ({deal_ok_s, store_ok_s})
                  2'b10:   count_d = count_q - 6'd1;
                  2'b01:   count_d = count_q + 6'd1;
                  default: count_d = count_q;
               endcase

               if ((bus.deal_en && !deal_ok_s) || (bus.store_en && !store_ok_s)) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end
         end

         ST_FILL: begin
            // One ordered card per cycle; tail doubles as the fill index.
            wr_en_s   = 1'b1;
            wr_addr_s = tail_q;
            wr_data_s = make_card(suit_q, rank_q);
            tail_d    = ptr_next(tail_q);
            count_d   = count_q + 6'd1;
            if ((suit_q == 2'd3) && (rank_q == 4'd13)) begin
               state_d = ST_IDLE;
            end else if (rank_q == 4'd13) begin
               rank_d = 4'd1;
               suit_d = suit_q + 2'd1;
            end else begin
               rank_d = rank_q + 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered status flags follow the next-state count and FSM state.
   always_comb begin
      empty_d = (count_d == 6'd0);
      full_d  = (count_d == FULL_CNT);
      busy_d  = (state_d == ST_FILL);
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         head_q       <= 6'd0;
         tail_q       <= 6'd0;
         count_q      <= 6'd0;
         card_out_q   <= '0;
         card_valid_q <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         rank_q       <= 4'd1;
         suit_q       <= 2'd0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         card_out_q   <= card_out_d;
         card_valid_q <= card_valid_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         rank_q       <= rank_d;
         suit_q       <= suit_d;
      end
   end

   // Card storage; contents are left alone by reset.
   always_ff @(posedge clock) begin
      if (wr_en_s && !reset) begin
         mem_q[wr_addr_s] <= wr_data_s;
      end
   end

   assign bus.card_out   = card_out_q;
   assign bus.card_valid = card_valid_q;
   assign bus.count      = count_q;
   assign bus.empty      = empty_q;
   assign bus.full       = full_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;

endmodule

// File: doc/card_deck.md
CARD_DECK -- requirements
Module: card_deck

Interface
REQ-001 SHALL have parameter DEPTH, default 52, meaning the maximum number of cards the queue holds.
REQ-002 SHALL have parameter CARD_W, default 16, meaning the card word width; bits [3:0] hold rank 1..13, bits [5:4] hold suit 0..3, and the remaining bits are zero.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port init, input, 1, a one-cycle request to load a fresh ordered 52-card deck.
REQ-006 SHALL have port store_en, input, 1, a request to push card_in at the tail.
REQ-007 SHALL have port card_in, input, CARD_W, the card pushed when store_en is accepted.
REQ-008 SHALL have port deal_en, input, 1, a request to pop the head card.
REQ-009 SHALL have port card_out, output, CARD_W, the popped card (registered).
REQ-010 SHALL have port card_valid, output, 1, a one-cycle pulse marking card_out valid.
REQ-011 SHALL have port count, output, 6, the number of cards currently held (0..52).
REQ-012 SHALL have ports empty and full, output, 1 each, asserted when count is 0 and 52 respectively.
REQ-013 SHALL have port busy, output, 1, high while an init fill is in progress.
REQ-014 SHALL have port err, output, 1, sticky; set by a rejected deal or store; cleared only by reset or init.

Function
REQ-015 SHALL store cards in a DEPTH-entry circular buffer addressed by a head pointer and a tail pointer, each 6 bits wide.
REQ-016 SHALL implement FSM states IDLE and FILL: IDLE moves to FILL when init=1, and FILL moves to IDLE after the cycle that writes entry 51.
REQ-017 SHALL, on entering FILL, clear head, tail, count and err; it SHALL then write entry i = {zeros, suit=i/13, rank=(i mod 13)+1} on fill cycle i, i=0..51, one entry per cycle.
REQ-018 SHALL hold busy=1 for exactly 52 cycles of FILL; on return to IDLE, count=52, head=0, tail=0, full=1.
REQ-019 SHALL ignore deal_en, store_en and init during FILL; these requests do not set err.
REQ-020 SHALL, when deal_en=1 in IDLE with count>0, drive card_out from the head entry and card_valid=1 on the next cycle, advance head, and decrement count (latency 1 cycle).
REQ-021 SHALL, when store_en=1 in IDLE with count<52, write card_in at the tail, advance tail, and increment count; the card is dealable on the following cycle.
REQ-022 SHALL advance each pointer from 51 to 0 (wrap-around); pointer values 52..63 never occur.
REQ-023 SHALL, on simultaneous deal_en and store_en with 0<count<52, perform both and leave count unchanged.
REQ-024 SHALL, on simultaneous deal_en and store_en with count=52, pop the old head card, then write card_in into the freed slot, with count staying 52.
REQ-025 SHALL, on simultaneous deal_en and store_en with count=0, reject the deal (card_valid=0, err=1) and accept the store (count becomes 1).
REQ-026 SHALL, for deal_en alone with count=0, produce card_valid=0, set err, and leave all state unchanged.
REQ-027 SHALL, for store_en alone with count=52, discard card_in, set err, and leave all state unchanged.
REQ-028 SHALL hold card_out at its last popped value between pulses; card_valid is never high for two cycles from a single request.
REQ-029 SHALL give init in IDLE priority over deal_en and store_en in the same cycle; the queue operations are dropped.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state=IDLE, head=0, tail=0, count=0, card_out=0, card_valid=0, err=0, busy=0, empty=1, full=0, regardless of any operation in progress, including mid-FILL.
REQ-031 SHALL leave buffer contents unspecified after reset; no output depends on them until written.

Verification
REQ-032 SHALL be covered by: reset, then init pulse -> busy high for 52 cycles, then count=52 and full=1; 52 consecutive deals -> card_out sequence 0x0001..0x000D, 0x0011..0x001D, 0x0021..0x002D, 0x0031..0x003D; then empty=1.
REQ-033 SHALL be covered by: after reset, store 0x0005 and 0x0023, then deal twice -> card_out 0x0005 then 0x0023, each one cycle after its deal, with count 2->1->0.
REQ-034 SHALL be covered by: deal while empty -> card_valid=0, err=1 and held until the next init; store while full (after init) -> count stays 52 and err=1.
REQ-035 SHALL be covered by: after init, deal 50 and store 50 distinct cards, interleaved so that tail wraps 51->0 -> the following deals return the remaining two ordered cards, then the stored cards in FIFO order.
REQ-036 SHALL be covered by: simultaneous deal+store at count=52 (card_in 0x0007) -> card_out 0x0001 and count 52, with 0x0007 emerging as the 52nd subsequent deal; simultaneous deal+store at count=0 -> err=1 and count=1.
REQ-037 SHALL be covered by: reset asserted on fill cycle 20 -> next cycle busy=0, count=0, empty=1; a subsequent init performs a full 52-cycle fill.
